full_adder_behavioral: RTL and testbench



---
 rtl/full_adder_behavioral.sv | 72 +++++++
 tb/tb_full_adder_behavioral.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_behavioral.sv
// Single-bit full adder with a stored carry for bit-serial, LSB-first word adds.
// Define FULL_ADDER_REG_OUT_EN to register sum/c_out/out_valid (1-cycle latency).
module full_adder_behavioral (
    input  logic clk,
    input  logic rst,
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in,
    input  logic in_valid,
    input  logic serial,
    output logic out_valid,
    output logic carry_q
);

    logic cin_e;
    logic s_c;
    logic co_c;

    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Stage p0: effective carry select and combinational add
    assign cin_e = serial ? carry_q : c_in;
    assign s_c   = fa_sum(a, b, cin_e);
    assign co_c  = fa_carry(a, b, cin_e);

    // Carry is captured in both modes so a non-serial LSB cycle seeds the chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (in_valid) begin
            carry_q <= co_c;
        end
    end

`ifdef FULL_ADDER_REG_OUT_EN
    logic sum_p1;
    logic co_p1;
    logic vld_p1;

    // Stage p1: registered outputs, held while no valid input arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p1 <= 1'b0;
            co_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1 <= s_c;
                co_p1  <= co_c;
            end
        end
    end

    assign sum       = sum_p1;
    assign c_out     = co_p1;
    assign out_valid = vld_p1;
`else
    assign sum       = s_c;
    assign c_out     = co_c;
    assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_full_adder_behavioral.sv
// Bench for full_adder_behavioral: truth table, serial word adds, stalls,
// async reset and random traffic against an arithmetic reference model.
module tb_full_adder_behavioral;

    logic clk;
    logic rst;
    logic sum;
    logic c_out;
    logic a;
    logic b;
    logic c_in;
    logic in_valid;
    logic serial;
    logic out_valid;
    logic carry_q;

    int pass_cnt;
    int total_cnt;

    // reference model state
    logic m_carry;
    logic m_sum;
    logic m_co;
    logic m_vld;
    logic obs_s;
    logic obs_co;

    typedef struct {
        logic a;
        logic b;
        logic c_in;
        logic exp_s;
        logic exp_co;
    } vec_t;

    vec_t tbl[8];

    full_adder_behavioral dut (
        .clk      (clk),
        .rst      (rst),
        .sum      (sum),
        .c_out    (c_out),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .in_valid (in_valid),
        .serial   (serial),
        .out_valid(out_valid),
        .carry_q  (carry_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    endtask

    // Drive one cycle starting just after a falling edge; returns at the next falling edge.
    task automatic step(input logic ia, input logic ib, input logic icin,
                        input logic ivld, input logic iser, input string nm);
        logic       cin_e;
        logic [1:0] tot;
        a = ia; b = ib; c_in = icin; in_valid = ivld; serial = iser;
        cin_e = iser ? m_carry : icin;
        tot   = 2'(int'(ia) + int'(ib) + int'(cin_e));
        #1;
`ifndef FULL_ADDER_REG_OUT_EN
        chk({nm, ".sum"}, sum, tot[0]);
        chk({nm, ".c_out"}, c_out, tot[1]);
        chk({nm, ".out_valid"}, out_valid, ivld);
        obs_s  = sum;
        obs_co = c_out;
`endif
        @(posedge clk);
        if (ivld) begin
            m_carry = tot[1];
            m_sum   = tot[0];
            m_co    = tot[1];
        end
        m_vld = ivld;
        #1;
        chk({nm, ".carry_q"}, carry_q, m_carry);
`ifdef FULL_ADDER_REG_OUT_EN
        chk({nm, ".sum"}, sum, m_sum);
        chk({nm, ".c_out"}, c_out, m_co);
        chk({nm, ".out_valid"}, out_valid, m_vld);
        obs_s  = sum;
        obs_co = c_out;
`endif
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_carry = 1'b0;
        m_sum   = 1'b0;
        m_co    = 1'b0;
        m_vld   = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // reset state; serial path uses carry 0 while reset is held
        rst = 1'b1; a = 1'b1; b = 1'b0; c_in = 1'b1; in_valid = 1'b1; serial = 1'b1;
        model_reset();
        #2;
        chk("rst.carry_q", carry_q, 1'b0);
`ifdef FULL_ADDER_REG_OUT_EN
        chk("rst.sum", sum, 1'b0);
        chk("rst.c_out", c_out, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
`else
        chk("rst.sum_follows", sum, 1'b1);
        chk("rst.c_out_follows", c_out, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // truth table sweep
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].a, tbl[i].b, tbl[i].c_in, 1'b1, 1'b0, $sformatf("tt%0d", i));
            chk($sformatf("tt%0d.tbl_sum", i), obs_s, tbl[i].exp_s);
            chk($sformatf("tt%0d.tbl_co", i), obs_co, tbl[i].exp_co);
        end

        // serial 3 + 1 = 4, LSB first
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "s31.b0");
        chk("s31.b0.s", obs_s, 1'b0);
        chk("s31.b0.cq", carry_q, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "s31.b1");
        chk("s31.b1.s", obs_s, 1'b0);
        chk("s31.b1.cq", carry_q, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "s31.b2");
        chk("s31.b2.s", obs_s, 1'b1);
        chk("s31.b2.cq", carry_q, 1'b0);

        // stall between serial bits: carry holds, serial=1 ignored
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "stall.seed");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("stall%0d", i));
            chk($sformatf("stall%0d.cq_hold", i), carry_q, 1'b1);
        end

        // async reset pulse between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst.carry_q", carry_q, 1'b0);
`ifdef FULL_ADDER_REG_OUT_EN
        chk("arst.out_valid", out_valid, 1'b0);
`endif
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "arst.next");
        chk("arst.next.s", obs_s, 1'b1);
        chk("arst.next.co", obs_co, 1'b0);

        // latency of outputs relative to a valid input
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lat.idle");
        a = 1'b1; b = 1'b1; c_in = 1'b0; in_valid = 1'b1; serial = 1'b0;
        #1;
`ifdef FULL_ADDER_REG_OUT_EN
        chk("lat.pre_vld", out_valid, 1'b0);
`else
        chk("lat.zero_vld", out_valid, 1'b1);
        chk("lat.zero_co", c_out, 1'b1);
`endif
        @(posedge clk);
        #1;
        chk("lat.post_sum", sum, 1'b0);
        chk("lat.post_co", c_out, 1'b1);
        chk("lat.post_vld", out_valid, 1'b1);
        chk("lat.cq", carry_q, 1'b1);
        m_carry = 1'b1; m_sum = 1'b0; m_co = 1'b1; m_vld = 1'b1;
        @(negedge clk);

        // serial select with stored carry 1 and c_in 0
        step(0, 0, 0, 1'b1, 1'b1, "sel.ser1");
        chk("sel.ser1.s", obs_s, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "sel.seed");
        step(0, 0, 0, 1'b1, 1'b0, "sel.ser0");
        chk("sel.ser0.s", obs_s, 1'b0);

        // random traffic against the arithmetic model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(3) != 0), 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
